// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and counter/divider sizing helpers.
// Latency: none (constants and elaboration-time functions only).
// Backpressure: none.
package vga_timing_pkg;

    // Default 640x480@60 timing from a 100 MHz system clock.
    localparam int DEF_CLK_DIV      = 4;
    localparam int DEF_H_DISPLAY    = 640;
    localparam int DEF_H_FRONT      = 16;
    localparam int DEF_H_SYNC       = 96;
    localparam int DEF_H_BACK       = 48;
    localparam int DEF_V_DISPLAY    = 480;
    localparam int DEF_V_FRONT      = 10;
    localparam int DEF_V_SYNC       = 2;
    localparam int DEF_V_BACK       = 33;
    localparam bit DEF_SYNC_POL     = 1'b0;
    localparam int DEF_SCREEN_WIDTH = 10;

    // Total positions in one line or one frame (display + porches + sync).
    function automatic int line_total(input int disp, input int front, input int sync, input int back);
        return disp + front + sync + back;
    endfunction

    // First position of the sync pulse.
    function automatic int sync_first(input int disp, input int front);
        return disp + front;
    endfunction

    // Last position of the sync pulse (inclusive).
    function automatic int sync_last(input int disp, input int front, input int sync);
        return disp + front + sync - 1;
    endfunction

    // Bits needed to count 0..n_states-1; never less than one bit.
    function automatic int cnt_width(input int n_states);
        return (n_states <= 1) ? 1 : $clog2(n_states);
    endfunction

    // Divider counter width for a given sys_clk-per-pixel ratio.
    function automatic int tick_cnt_width(input int clk_div);
        return cnt_width(clk_div);
    endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// Pixel-rate enable: divides sys_clk by CLK_DIV into a one-cycle p_tick pulse.
// Latency: first p_tick is high CLK_DIV-1 cycles after reset release (CLK_DIV=1: one cycle, then stuck high).
// Backpressure: none; free-running divider.
module pixel_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic p_tick
);

    localparam int            DW   = tick_cnt_width(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;

    // Next divider count, wrapping after the last sys_clk of a pixel period.
    always_comb begin
        div_nxt = (div_cnt == LAST) ? '0 : div_cnt + DW'(1);
    end

    // Divider state; p_tick is registered so it is high exactly while div_cnt sits at LAST
    // and stays low during reset even when CLK_DIV is 1.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt <= '0;
            p_tick  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            p_tick  <= (div_nxt == LAST);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate h/v counters driving hsync/vsync, video_on and x/y (macro VGA_FRAME_TICK_EN adds frame_tick/frame_cnt).
// Latency: outputs are registered on p_tick from the pre-increment counters, one pixel period behind them.
// Backpressure: none; free-running timebase, consumers sample on p_tick.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int H_DISPLAY    = DEF_H_DISPLAY,
    parameter int H_FRONT      = DEF_H_FRONT,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BACK       = DEF_H_BACK,
    parameter int V_DISPLAY    = DEF_V_DISPLAY,
    parameter int V_FRONT      = DEF_V_FRONT,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BACK       = DEF_V_BACK,
    parameter bit SYNC_POL     = DEF_SYNC_POL,
    parameter int SCREEN_WIDTH = DEF_SCREEN_WIDTH
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    output logic                    p_tick,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    video_on,
    output logic [SCREEN_WIDTH-1:0] x,
    output logic [SCREEN_WIDTH-1:0] y
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic                    frame_tick,
    output logic [15:0]             frame_cnt
`endif
);

    localparam int H_TOTAL = line_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = line_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS        = HW'(H_DISPLAY);
    localparam logic [HW-1:0] H_SYNC_FIRST = HW'(sync_first(H_DISPLAY, H_FRONT));
    localparam logic [HW-1:0] H_SYNC_LAST  = HW'(sync_last(H_DISPLAY, H_FRONT, H_SYNC));
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS        = VW'(V_DISPLAY);
    localparam logic [VW-1:0] V_SYNC_FIRST = VW'(sync_first(V_DISPLAY, V_FRONT));
    localparam logic [VW-1:0] V_SYNC_LAST  = VW'(sync_last(V_DISPLAY, V_FRONT, V_SYNC));

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_in_sync;
    logic          v_in_sync;
    logic          in_display;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .p_tick    (p_tick)
    );

    // Decode the current counter position into wrap, sync-window and visible-area flags.
    always_comb begin
        h_wrap     = (h_cnt == H_LAST);
        v_wrap     = (v_cnt == V_LAST);
        h_in_sync  = (h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST);
        v_in_sync  = (v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST);
        in_display = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    end

    // Position counters: h steps every pixel, v steps when h wraps, both wrap together at frame end.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (p_tick) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    // Registered pixel-pipeline outputs, all taken from the same pre-increment position so they stay aligned.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x        <= '0;
            y        <= '0;
            video_on <= 1'b0;
            hsync    <= ~SYNC_POL;
            vsync    <= ~SYNC_POL;
        end else if (p_tick) begin
            x        <= SCREEN_WIDTH'(h_cnt);
            y        <= SCREEN_WIDTH'(v_cnt);
            video_on <= in_display;
            hsync    <= h_in_sync ? SYNC_POL : ~SYNC_POL;
            vsync    <= v_in_sync ? SYNC_POL : ~SYNC_POL;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    // One-cycle end-of-frame pulse and free-running frame count, on the tick that wraps back to (0,0).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_tick <= p_tick && h_wrap && v_wrap;
            if (p_tick && h_wrap && v_wrap) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
module tb_vga_sync_gen;

    localparam int SW = 10;

    // Instance A: default 640x480 timing, CLK_DIV=4.
    localparam int A_DIV = 4;
    localparam int A_HT  = 800;
    localparam int A_VT  = 525;
    // Instance B: shrunken timing with CLK_DIV=1 so whole frames fit in a short run.
    localparam int B_HD = 16, B_HF = 4, B_HS = 6, B_HB = 4;
    localparam int B_VD = 8,  B_VF = 2, B_VS = 2, B_VB = 3;
    localparam int B_HT = 30;
    localparam int B_VT = 15;
    localparam int B_FRAME = 450;

    typedef struct packed {
        logic [SW-1:0] x;
        logic [SW-1:0] y;
        logic          hs;
        logic          vs;
        logic          von;
    } pix_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b1;
    logic rst_b_n = 1'b1;

    logic          pt_a, hs_a, vs_a, von_a;
    logic [SW-1:0] x_a, y_a;
    logic          pt_b, hs_b, vs_b, von_b;
    logic [SW-1:0] x_b, y_b;
`ifdef VGA_FRAME_TICK_EN
    logic          ft_a, ft_b;
    logic [15:0]   fc_a, fc_b;
`endif

    pix_t got_a, got_b;
    assign got_a = {x_a, y_a, hs_a, vs_a, von_a};
    assign got_b = {x_b, y_b, hs_b, vs_b, von_b};

    int n_tests = 0;
    int n_fail  = 0;

    vga_sync_gen dut_a (
        .sys_clk   (clk),
        .sys_rst_n (rst_a_n),
        .p_tick    (pt_a),
        .hsync     (hs_a),
        .vsync     (vs_a),
        .video_on  (von_a),
        .x         (x_a),
        .y         (y_a)
`ifdef VGA_FRAME_TICK_EN
        ,
        .frame_tick(ft_a),
        .frame_cnt (fc_a)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(1),
        .H_DISPLAY(B_HD), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_DISPLAY(B_VD), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB)
    ) dut_b (
        .sys_clk   (clk),
        .sys_rst_n (rst_b_n),
        .p_tick    (pt_b),
        .hsync     (hs_b),
        .vsync     (vs_b),
        .video_on  (von_b),
        .x         (x_b),
        .y         (y_b)
`ifdef VGA_FRAME_TICK_EN
        ,
        .frame_tick(ft_b),
        .frame_cnt (fc_b)
`endif
    );

    // Expected outputs for a counter position (active-low syncs).
    function automatic pix_t model_pix(input int h, input int v, input int hd, input int hf, input int hs,
                                       input int vd, input int vf, input int vs);
        pix_t p;
        p.x   = SW'(h);
        p.y   = SW'(v);
        p.von = (h < hd) && (v < vd);
        p.hs  = (h >= hd + hf && h < hd + hf + hs) ? 1'b0 : 1'b1;
        p.vs  = (v >= vd + vf && v < vd + vf + vs) ? 1'b0 : 1'b1;
        return p;
    endfunction

    // Reference model A: pushes the expected pixel on every modelled pixel edge.
    int   ma_div = 0, ma_h = 0, ma_v = 0;
    logic ma_pt  = 1'b0;
    pix_t qa[$];
    always @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            ma_div = 0; ma_h = 0; ma_v = 0; ma_pt = 1'b0; qa.delete();
        end else begin
            if (ma_pt) begin
                qa.push_back(model_pix(ma_h, ma_v, 640, 16, 96, 480, 10, 2));
                if (ma_h == A_HT - 1) begin
                    ma_h = 0;
                    ma_v = (ma_v == A_VT - 1) ? 0 : ma_v + 1;
                end else ma_h++;
            end
            ma_div = (ma_div == A_DIV - 1) ? 0 : ma_div + 1;
            ma_pt  = (ma_div == A_DIV - 1);
        end
    end

    // Reference model B (CLK_DIV=1) including frame tick/count.
    int          mb_h = 0, mb_v = 0;
    logic        mb_pt = 1'b0, mb_ft = 1'b0;
    logic [15:0] mb_fc = 16'd0;
    pix_t qb[$];
    always @(posedge clk or negedge rst_b_n) begin
        if (!rst_b_n) begin
            mb_h = 0; mb_v = 0; mb_pt = 1'b0; mb_ft = 1'b0; mb_fc = 16'd0; qb.delete();
        end else begin
            mb_ft = 1'b0;
            if (mb_pt) begin
                qb.push_back(model_pix(mb_h, mb_v, B_HD, B_HF, B_HS, B_VD, B_VF, B_VS));
                if (mb_h == B_HT - 1) begin
                    mb_h = 0;
                    if (mb_v == B_VT - 1) begin
                        mb_v = 0; mb_ft = 1'b1; mb_fc = mb_fc + 16'd1;
                    end else mb_v++;
                end else mb_h++;
            end
            mb_pt = 1'b1;
        end
    end

    task automatic test_reset();
        pix_t e;
        #1 rst_a_n = 1'b0; rst_b_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({got_a, pt_a} !== {SW'(0), SW'(0), 3'b110, 1'b0}) begin
            n_fail++; $display("FAIL reset_a: got %h ptick %b want x=0 y=0 hs=1 vs=1 von=0 ptick=0", got_a, pt_a);
        end
        n_tests++;
        if (pt_b !== 1'b0) begin n_fail++; $display("FAIL reset_ptick_div1: got %b want 0", pt_b); end
        rst_a_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (pt_a !== (c == 3)) begin n_fail++; $display("FAIL first_ptick c=%0d: got %b want %b", c, pt_a, (c == 3)); end
            if (c < 4) begin
                n_tests++;
                if (got_a !== {SW'(0), SW'(0), 3'b110}) begin
                    n_fail++; $display("FAIL pre_tick c=%0d: got %h want reset values", c, got_a);
                end
            end
        end
        n_tests++;
        if (x_a !== 0 || y_a !== 0 || von_a !== 1'b1) begin
            n_fail++; $display("FAIL first_pixel: got x=%0d y=%0d von=%b want 0 0 1", x_a, y_a, von_a);
        end
        n_tests++;
        if (qa.size() == 0) begin n_fail++; $display("FAIL first_pixel_sb: no expected entry"); end
        else begin
            e = qa.pop_front();
            if (got_a !== e) begin n_fail++; $display("FAIL first_pixel_sb: got %h want %h", got_a, e); end
        end
    endtask

    task automatic test_divider();
        pix_t e;
        int highs = 0, last = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_tests++;
            if (pt_a !== ma_pt) begin n_fail++; $display("FAIL div_ptick c=%0d: got %b want %b", c, pt_a, ma_pt); end
            if (pt_a === 1'b1) begin
                highs++;
                if (last >= 0 && c - last != 4) begin
                    n_fail++; $display("FAIL div_gap: got %0d want 4", c - last);
                end
                last = c;
            end
            if (qa.size() != 0) begin
                e = qa.pop_front(); n_tests++;
                if (got_a !== e) begin n_fail++; $display("FAIL div_pix: got %h want %h", got_a, e); end
            end
        end
        n_tests++;
        if (highs != 10) begin n_fail++; $display("FAIL div_period: got %0d highs want 10", highs); end
    endtask

    task automatic test_line();
        pix_t e;
        int hs_low = 0, hs_first = -1, hs_last = -1, von_cnt = 0, x_max = 0, t0 = -1, t1 = -1;
        for (int c = 0; c < 6600; c++) begin
            @(negedge clk);
            n_tests++;
            if (pt_a !== ma_pt) begin n_fail++; $display("FAIL line_ptick c=%0d: got %b want %b", c, pt_a, ma_pt); end
`ifdef VGA_FRAME_TICK_EN
            n_tests++;
            if (ft_a !== 1'b0 || fc_a !== 16'd0) begin
                n_fail++; $display("FAIL line_frame: got tick=%b cnt=%0d want 0 0", ft_a, fc_a);
            end
`endif
            if (qa.size() != 0) begin
                e = qa.pop_front(); n_tests++;
                if (got_a !== e) begin n_fail++; $display("FAIL line_pix: got %h want %h", got_a, e); end
                if (y_a == 1) begin
                    if (hs_a == 1'b0) begin
                        hs_low++;
                        if (hs_first < 0) hs_first = int'(x_a);
                        hs_last = int'(x_a);
                    end
                    if (von_a == 1'b1) von_cnt++;
                    if (int'(x_a) > x_max) x_max = int'(x_a);
                    if (x_a == 0) t0 = c;
                end
                if (y_a == 2 && x_a == 0) t1 = c;
            end
        end
        n_tests++; if (hs_low != 96) begin n_fail++; $display("FAIL hsync_width: got %0d want 96", hs_low); end
        n_tests++; if (hs_first != 656) begin n_fail++; $display("FAIL hsync_first: got %0d want 656", hs_first); end
        n_tests++; if (hs_last != 751) begin n_fail++; $display("FAIL hsync_last: got %0d want 751", hs_last); end
        n_tests++; if (von_cnt != 640) begin n_fail++; $display("FAIL video_on_cnt: got %0d want 640", von_cnt); end
        n_tests++; if (x_max != 799) begin n_fail++; $display("FAIL x_max: got %0d want 799", x_max); end
        n_tests++;
        if (t0 < 0 || t1 < 0 || t1 - t0 != 3200) begin
            n_fail++; $display("FAIL line_len: got t0=%0d t1=%0d want spacing 3200", t0, t1);
        end
        rst_a_n = 1'b0;
    endtask

    task automatic test_clkdiv1();
        pix_t e;
        int highs = 0, first_pix = -1;
        rst_b_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_tests++;
            if (pt_b !== mb_pt) begin n_fail++; $display("FAIL div1_ptick c=%0d: got %b want %b", c, pt_b, mb_pt); end
            if (pt_b === 1'b1) highs++;
            if (qb.size() != 0) begin
                e = qb.pop_front(); n_tests++;
                if (got_b !== e) begin n_fail++; $display("FAIL div1_pix: got %h want %h", got_b, e); end
                if (first_pix < 0) first_pix = c;
            end
        end
        n_tests++; if (highs != 30) begin n_fail++; $display("FAIL div1_stuck: got %0d highs want 30", highs); end
        n_tests++; if (first_pix != 1) begin n_fail++; $display("FAIL div1_first: got %0d want 1", first_pix); end
        n_tests++; if (x_b !== SW'(28)) begin n_fail++; $display("FAIL div1_rate: got x=%0d want 28", x_b); end
    endtask

    task automatic test_frame();
        pix_t e;
        int vs_low = 0, vs_ymin = 999, vs_ymax = -1, fr = 0, t_a = -1, t_b = -1, von_bad = 0;
        int ticks = 0, tk1 = -1, tk2 = -1, cnt1 = -1, cnt2 = -1;
        for (int c = 0; c < 1400; c++) begin
            @(negedge clk);
`ifdef VGA_FRAME_TICK_EN
            n_tests++;
            if (ft_b !== mb_ft || fc_b !== mb_fc) begin
                n_fail++; $display("FAIL frame_tick_cnt: got %b/%0d want %b/%0d", ft_b, fc_b, mb_ft, mb_fc);
            end
            if (ft_b === 1'b1) begin
                ticks++;
                if (ticks == 1) begin tk1 = c; cnt1 = int'(fc_b); end
                if (ticks == 2) begin tk2 = c; cnt2 = int'(fc_b); end
            end
`endif
            if (qb.size() != 0) begin
                e = qb.pop_front(); n_tests++;
                if (got_b !== e) begin n_fail++; $display("FAIL frame_pix: got %h want %h", got_b, e); end
                if (x_b == 0 && y_b == 0) begin
                    fr++;
                    if (fr == 1) t_a = c;
                    if (fr == 2) t_b = c;
                end
                if (fr == 1) begin
                    if (vs_b == 1'b0) begin
                        vs_low++;
                        if (int'(y_b) < vs_ymin) vs_ymin = int'(y_b);
                        if (int'(y_b) > vs_ymax) vs_ymax = int'(y_b);
                    end
                    if (von_b == 1'b1 && y_b >= B_VD) von_bad++;
                end
            end
        end
        n_tests++; if (vs_low != 60) begin n_fail++; $display("FAIL vsync_width: got %0d want 60", vs_low); end
        n_tests++;
        if (vs_ymin != 10 || vs_ymax != 11) begin
            n_fail++; $display("FAIL vsync_rows: got %0d..%0d want 10..11", vs_ymin, vs_ymax);
        end
        n_tests++; if (von_bad != 0) begin n_fail++; $display("FAIL von_blank: got %0d want 0", von_bad); end
        n_tests++;
        if (t_a < 0 || t_b - t_a != B_FRAME) begin
            n_fail++; $display("FAIL frame_len: got %0d want %0d", t_b - t_a, B_FRAME);
        end
`ifdef VGA_FRAME_TICK_EN
        n_tests++;
        if (tk1 < 0 || tk2 - tk1 != B_FRAME) begin
            n_fail++; $display("FAIL frame_tick_period: got %0d want %0d", tk2 - tk1, B_FRAME);
        end
        n_tests++;
        if (cnt1 != 1 || cnt2 != 2) begin
            n_fail++; $display("FAIL frame_cnt_seq: got %0d,%0d want 1,2", cnt1, cnt2);
        end
`endif
    endtask

    task automatic test_midframe_reset();
        pix_t e;
        bit found = 1'b0;
        int first = -1, second = -1;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (qb.size() != 0) begin
                e = qb.pop_front(); n_tests++;
                if (got_b !== e) begin n_fail++; $display("FAIL mid_pre_pix: got %h want %h", got_b, e); end
            end
            if (x_b == 10 && y_b == 5) found = 1'b1;
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL mid_reach: got timeout want x=10 y=5"); end
        #1 rst_b_n = 1'b0;
        #1;
        n_tests++;
        if ({got_b, pt_b} !== {SW'(0), SW'(0), 3'b110, 1'b0}) begin
            n_fail++; $display("FAIL mid_async: got %h ptick %b want reset values", got_b, pt_b);
        end
`ifdef VGA_FRAME_TICK_EN
        n_tests++;
        if (ft_b !== 1'b0 || fc_b !== 16'd0) begin
            n_fail++; $display("FAIL mid_async_frame: got %b/%0d want 0/0", ft_b, fc_b);
        end
`endif
        @(negedge clk);
        rst_b_n = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (qb.size() != 0) begin
                e = qb.pop_front(); n_tests++;
                if (got_b !== e) begin n_fail++; $display("FAIL mid_post_pix: got %h want %h", got_b, e); end
                if (x_b == 0 && y_b == 0) begin
                    if (first < 0) first = c;
                    else if (second < 0) second = c;
                end
            end
        end
        n_tests++; if (first != 1) begin n_fail++; $display("FAIL mid_restart: got %0d want 1", first); end
        n_tests++;
        if (second - first != B_FRAME) begin
            n_fail++; $display("FAIL mid_frame_len: got %0d want %0d", second - first, B_FRAME);
        end
    endtask

`ifdef VGA_FRAME_TICK_EN
    task automatic test_frame_wrap();
        pix_t e;
        bit seen = 1'b0;
        @(negedge clk);
        if (qb.size() != 0) begin
            e = qb.pop_front(); n_tests++;
            if (got_b !== e) begin n_fail++; $display("FAIL wrap_pix: got %h want %h", got_b, e); end
        end
        force dut_b.frame_cnt = 16'hFFFF;
        mb_fc = 16'hFFFF;
        #1 release dut_b.frame_cnt;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk);
            if (qb.size() != 0) begin
                e = qb.pop_front(); n_tests++;
                if (got_b !== e) begin n_fail++; $display("FAIL wrap_pix: got %h want %h", got_b, e); end
            end
            if (ft_b === 1'b1) begin
                seen = 1'b1;
                n_tests++;
                if (fc_b !== 16'd0) begin n_fail++; $display("FAIL frame_cnt_wrap: got %h want 0000", fc_b); end
            end
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL frame_wrap_tick: got timeout want a frame_tick"); end
    endtask
`endif

    initial begin
        test_reset();
        test_divider();
        test_line();
        test_clkdiv1();
        test_frame();
        test_midframe_reset();
`ifdef VGA_FRAME_TICK_EN
        test_frame_wrap();
`endif
        rst_b_n = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
